// File: rtl/storage_load_sequencer.sv
// Host load front-end: turns a header/row word stream into storage write cycles,
// then steps locator reset, code-fetch enable and controller enable in order.
module storage_load_sequencer #(
    parameter int INDEX_WIDTH = 32,
    parameter int CODE_WIDTH  = 12
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   host_valid,
    input  logic [47:0]            host_data,
    output logic                   host_ready,
    input  logic                   run_abort,
    output logic [47:0]            weight_write_data,
    output logic [INDEX_WIDTH-1:0] weight_write_layer_index,
    output logic [INDEX_WIDTH-1:0] weight_write_row_index,
    output logic                   weight_is_write,
    output logic [47:0]            input_write_data,
    output logic [INDEX_WIDTH-1:0] input_write_layer_index,
    output logic [INDEX_WIDTH-1:0] input_write_row_index,
    output logic                   input_is_write,
    output logic [47:0]            label_write_data,
    output logic [INDEX_WIDTH-1:0] label_write_layer_index,
    output logic [INDEX_WIDTH-1:0] label_write_row_index,
    output logic                   label_is_write,
    output logic [INDEX_WIDTH-1:0] code_write_line,
    output logic [CODE_WIDTH-1:0]  code_write_data,
    output logic                   code_is_write,
    output logic                   matrix_storage_locator_reset,
    output logic                   code_storage_enable,
    output logic                   controller_enable,
    output logic                   busy,
    output logic                   running
);

    typedef enum logic [2:0] {IDLE, LOAD, LOC_RST, CODE_EN, RUN} state_t;

    state_t      state;
    logic [1:0]  target;
    logic [15:0] base;
    logic [15:0] count;
    logic [15:0] row_ctr;

    logic [1:0]  hdr_target;
    logic [15:0] hdr_base;
    logic [15:0] hdr_count;
    logic [15:0] code_line;
    logic        last_row;

    assign hdr_target = host_data[47:46];
    assign hdr_base   = host_data[45:30];
    assign hdr_count  = host_data[29:14];
    assign code_line  = base + row_ctr;
    assign last_row   = (row_ctr == count - 16'd1);
    assign host_ready = (state == IDLE) || (state == LOAD);

    // Strobes and locator reset default low each cycle; storage fields hold
    // their last written value until their own storage is written again.
    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state                        <= IDLE;
            target                       <= 2'd0;
            base                         <= 16'd0;
            count                        <= 16'd0;
            row_ctr                      <= 16'd0;
            weight_write_data            <= '0;
            weight_write_layer_index     <= '0;
            weight_write_row_index       <= '0;
            weight_is_write              <= 1'b0;
            input_write_data             <= '0;
            input_write_layer_index      <= '0;
            input_write_row_index        <= '0;
            input_is_write               <= 1'b0;
            label_write_data             <= '0;
            label_write_layer_index      <= '0;
            label_write_row_index        <= '0;
            label_is_write               <= 1'b0;
            code_write_line              <= '0;
            code_write_data              <= '0;
            code_is_write                <= 1'b0;
            matrix_storage_locator_reset <= 1'b0;
            code_storage_enable          <= 1'b0;
            controller_enable            <= 1'b0;
            busy                         <= 1'b0;
            running                      <= 1'b0;
        end else begin
            weight_is_write              <= 1'b0;
            input_is_write               <= 1'b0;
            label_is_write               <= 1'b0;
            code_is_write                <= 1'b0;
            matrix_storage_locator_reset <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_valid) begin
                        busy <= 1'b1;
                        if (hdr_count != 16'd0) begin
                            target  <= hdr_target;
                            base    <= hdr_base;
                            count   <= hdr_count;
                            row_ctr <= 16'd0;
                            state   <= LOAD;
                        end else begin
                            matrix_storage_locator_reset <= 1'b1;
                            state                        <= LOC_RST;
                        end
                    end
                end
                LOAD: begin
                    if (host_valid) begin
                        case (target)
                            2'b00: begin
                                weight_write_data        <= host_data;
                                weight_write_layer_index <= INDEX_WIDTH'(base);
                                weight_write_row_index   <= INDEX_WIDTH'(row_ctr);
                                weight_is_write          <= 1'b1;
                            end
                            2'b01: begin
                                input_write_data         <= host_data;
                                input_write_layer_index  <= INDEX_WIDTH'(base);
                                input_write_row_index    <= INDEX_WIDTH'(row_ctr);
                                input_is_write           <= 1'b1;
                            end
                            2'b10: begin
                                label_write_data         <= host_data;
                                label_write_layer_index  <= INDEX_WIDTH'(base);
                                label_write_row_index    <= INDEX_WIDTH'(row_ctr);
                                label_is_write           <= 1'b1;
                            end
                            default: begin
                                code_write_line          <= INDEX_WIDTH'(code_line);
                                code_write_data          <= host_data[CODE_WIDTH-1:0];
                                code_is_write            <= 1'b1;
                            end
                        endcase
                        if (last_row) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            row_ctr <= row_ctr + 16'd1;
                        end
                    end
                end
                LOC_RST: begin
                    code_storage_enable <= 1'b1;
                    state               <= CODE_EN;
                end
                CODE_EN: begin
                    controller_enable <= 1'b1;
                    running           <= 1'b1;
                    state             <= RUN;
                end
                RUN: begin
                    if (run_abort) begin
                        code_storage_enable <= 1'b0;
                        controller_enable   <= 1'b0;
                        running             <= 1'b0;
                        busy                <= 1'b0;
                        state               <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
